// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of the single-port Data_mem.
//   Port A (cpu_*) is the CPU load/store path. Port B (dbg_*) is the
//   loader/inspector path. At most one access is issued per cycle, and grants
//   are combinational in the same cycle as the request. Read data (1-cycle
//   latency) is steered back to its owner by rvalid. Two mechanisms protect
//   the loader: a starvation counter forces a one-cycle dbg grant, and
//   prog_mode gives dbg exclusive ownership of the memory.
// Ports:
//   clock, rst_n                  clock, synchronous active-low reset
//   prog_mode                     loader-exclusive mode request
//   cpu_req/we/addr/wdata         CPU request (held until cpu_gnt)
//   cpu_gnt/stall/rvalid/rdata    CPU grant, stall, read response
//   dbg_req/we/addr/wdata         loader request (held until dbg_gnt)
//   dbg_gnt/rvalid/rdata          loader grant, read response
//   mem_en/we/addr/wdata          memory command
//   mem_rdata                     memory read data, valid the cycle after a read
module dmem_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          prog_mode,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {NORM, DRAIN, PROG} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;   // 1 = dbg owns the in-flight read
  logic          force_dbg;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = '0;
    force_dbg    = 1'b0;
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;
    case (state_q)
      NORM: begin
        // A prog_mode change wins over requests: nothing is granted while the
        // mode switches.
        if (prog_mode) begin
          state_d = rd_pend_q ? DRAIN : PROG;
        end else begin
          force_dbg = (STARVE_LIMIT != 0) && (starve_cnt_q == LIM);
          dbg_gnt   = dbg_req & (~cpu_req | force_dbg);
          cpu_gnt   = cpu_req & ~dbg_gnt;
          // Counter clears on the forced grant, so the force lasts one cycle.
          if (dbg_req && !dbg_gnt)
            starve_cnt_d = (starve_cnt_q == LIM) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
      end
      // Dead cycle while the last read response drains; no new grants.
      DRAIN: state_d = prog_mode ? PROG : NORM;
      PROG: begin
        if (!prog_mode) state_d = rd_pend_q ? DRAIN : NORM;
        else            dbg_gnt = dbg_req;
      end
      default: state_d = NORM;
    endcase
    if (!rst_n) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;

  // With no grant the CPU port drives addr/wdata; only mem_en/mem_we gate.
  assign mem_en     = cpu_gnt | dbg_gnt;
  assign mem_we     = dbg_gnt ? dbg_we    : (cpu_gnt & cpu_we);
  assign mem_addr   = dbg_gnt ? dbg_addr  : cpu_addr;
  assign mem_wdata  = dbg_gnt ? dbg_wdata : cpu_wdata;

  assign rd_pend_d  = mem_en & ~mem_we;
  assign rd_owner_d = dbg_gnt;

  assign cpu_rvalid = rst_n & rd_pend_q & ~rd_owner_q;
  assign dbg_rvalid = rst_n & rd_pend_q &  rd_owner_q;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= NORM;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

endmodule
